// File: rtl/regfile_wb_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : regfile_wb_arbiter_if
// Purpose  : Writeback request, register-file write and hazard-query bundle
//            for regfile_wb_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface regfile_wb_arbiter_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);
  logic              alloc_valid;
  logic [ADDR_W-1:0] alloc_rd;
  logic              req0_valid;
  logic [ADDR_W-1:0] req0_rd;
  logic [DATA_W-1:0] req0_data;
  logic              req0_ready;
  logic              req1_valid;
  logic [ADDR_W-1:0] req1_rd;
  logic [DATA_W-1:0] req1_data;
  logic              req1_ready;
  logic [ADDR_W-1:0] RD;
  logic [DATA_W-1:0] WRITE_DATA;
  logic              reg_wr;
  logic [ADDR_W-1:0] RS;
  logic [ADDR_W-1:0] RT;
  logic              rs_busy;
  logic              rt_busy;

  modport master (
    output alloc_valid, alloc_rd,
    output req0_valid, req0_rd, req0_data,
    output req1_valid, req1_rd, req1_data,
    output RS, RT,
    input  req0_ready, req1_ready,
    input  RD, WRITE_DATA, reg_wr,
    input  rs_busy, rt_busy
  );

  modport slave (
    input  alloc_valid, alloc_rd,
    input  req0_valid, req0_rd, req0_data,
    input  req1_valid, req1_rd, req1_data,
    input  RS, RT,
    output req0_ready, req1_ready,
    output RD, WRITE_DATA, reg_wr,
    output rs_busy, rt_busy
  );
endinterface
`default_nettype wire

// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : regfile_wb_arbiter
// Purpose  : Round-robin arbiter sharing the register-file write port between
//            the ALU (req0) and the load unit (req1), with a registered write
//            stage and a per-register pending-write scoreboard.
//            Option macro WB_R0_FILTER_EN: suppress reg_wr for rd==0 writes.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_wb_arbiter #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32,
  parameter int NREG   = 32
) (
  input wire clk,
  input wire rst,
  regfile_wb_arbiter_if.slave bus
);

  logic              w_gnt0;
  logic              w_gnt1;
  logic              w_xfer;
  logic              w_wr;
  logic [ADDR_W-1:0] w_rd;
  logic [DATA_W-1:0] w_data;
  logic [NREG-1:0]   w_busy_nxt;

  logic              r_last_grant;
  logic              r_reg_wr;
  logic [ADDR_W-1:0] r_rd;
  logic [DATA_W-1:0] r_wdata;
  logic [NREG-1:0]   r_busy;

  // r_last_grant==1 means req1 was served last, so req0 wins the next tie.
  assign w_gnt0 = bus.req0_valid && (!bus.req1_valid || r_last_grant);
  assign w_gnt1 = bus.req1_valid && (!bus.req0_valid || !r_last_grant);
  assign w_xfer = w_gnt0 || w_gnt1;
  assign w_rd   = w_gnt0 ? bus.req0_rd   : bus.req1_rd;
  assign w_data = w_gnt0 ? bus.req0_data : bus.req1_data;

`ifdef WB_R0_FILTER_EN
  assign w_wr = w_xfer && (w_rd != '0);
`else
  assign w_wr = w_xfer;
`endif

  // Allocation is applied after the clear so a new producer keeps the bit set.
  always_comb begin
    w_busy_nxt = r_busy;
    if (w_xfer) begin
      w_busy_nxt[w_rd] = 1'b0;
    end
    if (bus.alloc_valid && (bus.alloc_rd != '0)) begin
      w_busy_nxt[bus.alloc_rd] = 1'b1;
    end
    w_busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_grant <= 1'b1;
      r_reg_wr     <= 1'b0;
      r_rd         <= '0;
      r_wdata      <= '0;
      r_busy       <= '0;
    end else begin
      r_reg_wr <= w_wr;
      r_busy   <= w_busy_nxt;
      if (w_xfer) begin
        r_rd         <= w_rd;
        r_wdata      <= w_data;
        r_last_grant <= w_gnt1;
      end
    end
  end

  assign bus.req0_ready = w_gnt0;
  assign bus.req1_ready = w_gnt1;
  assign bus.RD         = r_rd;
  assign bus.WRITE_DATA = r_wdata;
  assign bus.reg_wr     = r_reg_wr;
  assign bus.rs_busy    = r_busy[bus.RS];
  assign bus.rt_busy    = r_busy[bus.RT];

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_wb_arbiter
// Purpose  : Vector-table bench for regfile_wb_arbiter with a write-stage
//            scoreboard and a reference busy-bit model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_wb_arbiter;

`ifdef WB_R0_FILTER_EN
  localparam bit c_R0_FILTER = 1'b1;
`else
  localparam bit c_R0_FILTER = 1'b0;
`endif

  typedef struct {
    logic        v0;
    logic [4:0]  rd0;
    logic [31:0] d0;
    logic        v1;
    logic [4:0]  rd1;
    logic [31:0] d1;
    logic        av;
    logic [4:0]  ard;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic        e0;
    logic        e1;
  } vec_t;

  typedef struct {
    logic        wr;
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  regfile_wb_arbiter_if #(.ADDR_W(5), .DATA_W(32)) bus ();

  regfile_wb_arbiter #(.ADDR_W(5), .DATA_W(32), .NREG(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  wb_t         sb_q[$];
  logic [31:0] m_busy;
  logic [4:0]  m_rd;
  logic [31:0] m_wd;
  int          n_checks = 0;
  int          n_errors = 0;

  function automatic vec_t mk(input logic v0, input logic [4:0] rd0, input logic [31:0] d0,
                              input logic v1, input logic [4:0] rd1, input logic [31:0] d1,
                              input logic av, input logic [4:0] ard,
                              input logic [4:0] rs, input logic [4:0] rt,
                              input logic e0, input logic e1);
    vec_t v;
    v.v0 = v0; v.rd0 = rd0; v.d0 = d0;
    v.v1 = v1; v.rd1 = rd1; v.d1 = d1;
    v.av = av; v.ard = ard; v.rs = rs; v.rt = rt;
    v.e0 = e0; v.e1 = e1;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    bus.req0_valid  = v.v0;
    bus.req0_rd     = v.rd0;
    bus.req0_data   = v.d0;
    bus.req1_valid  = v.v1;
    bus.req1_rd     = v.rd1;
    bus.req1_data   = v.d1;
    bus.alloc_valid = v.av;
    bus.alloc_rd    = v.ard;
    bus.RS          = v.rs;
    bus.RT          = v.rt;
  endtask

  task automatic run_cycle(input vec_t v, input int idx);
    wb_t        e;
    logic       xfer;
    logic [4:0] g_rd;
    @(posedge clk);
    #1;
    rst = 1'b0;
    apply(v);
    @(negedge clk);
    check($sformatf("req0_ready[%0d]", idx), {31'd0, bus.req0_ready}, {31'd0, v.e0});
    check($sformatf("req1_ready[%0d]", idx), {31'd0, bus.req1_ready}, {31'd0, v.e1});
    if (sb_q.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL sb_empty[%0d]: got 0 entries expected 1", idx);
    end else begin
      e = sb_q.pop_front();
      check($sformatf("reg_wr[%0d]", idx), {31'd0, bus.reg_wr}, {31'd0, e.wr});
      check($sformatf("RD[%0d]", idx), {27'd0, bus.RD}, {27'd0, e.rd});
      check($sformatf("WRITE_DATA[%0d]", idx), bus.WRITE_DATA, e.data);
    end
    check($sformatf("rs_busy[%0d]", idx), {31'd0, bus.rs_busy}, {31'd0, m_busy[v.rs]});
    check($sformatf("rt_busy[%0d]", idx), {31'd0, bus.rt_busy}, {31'd0, m_busy[v.rt]});
    // Predict the effect of the coming edge.
    xfer = v.e0 || v.e1;
    g_rd = v.e0 ? v.rd0 : v.rd1;
    if (xfer) begin
      m_rd = g_rd;
      m_wd = v.e0 ? v.d0 : v.d1;
      m_busy[g_rd] = 1'b0;
    end
    if (v.av && v.ard != 5'd0) m_busy[v.ard] = 1'b1;
    sb_q.push_back('{xfer && !(c_R0_FILTER && g_rd == 5'd0), m_rd, m_wd});
  endtask

  task automatic do_reset(input int n, input vec_t v);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      rst = 1'b1;
      apply(v);
      if (i >= 1) begin
        @(negedge clk);
        check("reset_reg_wr", {31'd0, bus.reg_wr}, 32'd0);
        check("reset_RD", {27'd0, bus.RD}, 32'd0);
        check("reset_WRITE_DATA", bus.WRITE_DATA, 32'd0);
      end
    end
    sb_q.delete();
    m_busy = '0;
    m_rd   = '0;
    m_wd   = '0;
    sb_q.push_back('{1'b0, 5'd0, 32'd0});
  endtask

  initial begin
    vec_t tbl[$];
    vec_t idle;
    int   k;
    idle = mk(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    apply(idle);

    // Contention from reset, singles, idle tie-hold, same-rd, r0 write.
    tbl.push_back(mk(1, 5'd5, 32'hA0, 1, 5'd6, 32'hB0, 0, 5'd0, 5'd5, 5'd6, 1, 0));
    tbl.push_back(mk(1, 5'd5, 32'hA1, 1, 5'd6, 32'hB0, 0, 5'd0, 5'd5, 5'd6, 0, 1));
    tbl.push_back(mk(1, 5'd5, 32'hA1, 1, 5'd6, 32'hB1, 0, 5'd0, 5'd5, 5'd6, 1, 0));
    tbl.push_back(mk(1, 5'd5, 32'hA2, 1, 5'd6, 32'hB1, 0, 5'd0, 5'd5, 5'd6, 0, 1));
    tbl.push_back(mk(1, 5'd1, 32'h8,  0, 5'd0, 32'h0,  0, 5'd0, 5'd1, 5'd0, 1, 0));
    tbl.push_back(mk(0, 5'd0, 32'h0,  1, 5'd2, 32'h1234, 0, 5'd0, 5'd1, 5'd2, 0, 1));
    tbl.push_back(idle);
    tbl.push_back(mk(1, 5'd3, 32'hC0, 1, 5'd4, 32'hD0, 0, 5'd0, 5'd3, 5'd4, 1, 0));
    tbl.push_back(mk(1, 5'd7, 32'hC1, 1, 5'd4, 32'hD0, 0, 5'd0, 5'd7, 5'd4, 0, 1));
    tbl.push_back(mk(1, 5'd9, 32'hE0, 1, 5'd9, 32'hF0, 0, 5'd0, 5'd9, 5'd9, 1, 0));
    tbl.push_back(mk(1, 5'd10, 32'hE1, 1, 5'd9, 32'hF0, 0, 5'd0, 5'd9, 5'd10, 0, 1));
    tbl.push_back(mk(1, 5'd0, 32'hFFFF, 0, 5'd0, 32'h0, 0, 5'd0, 5'd0, 5'd0, 1, 0));
    tbl.push_back(idle);

    do_reset(2, idle);
    k = 0;
    foreach (tbl[i]) begin
      run_cycle(tbl[i], k);
      k++;
    end

    // Scoreboard: alloc, clear by write, alloc+clear same cycle, r0 alloc ignored.
    run_cycle(mk(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 1, 5'd5, 5'd5, 5'd0, 0, 0), k++);
    run_cycle(mk(0, 5'd0, 32'h0, 1, 5'd5, 32'h55, 1, 5'd0, 5'd5, 5'd0, 0, 1), k++);
    run_cycle(mk(1, 5'd5, 32'h66, 0, 5'd0, 32'h0, 1, 5'd5, 5'd5, 5'd0, 1, 0), k++);
    run_cycle(mk(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 1, 5'd7, 5'd5, 5'd7, 0, 0), k++);
    run_cycle(mk(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 1, 5'd3, 5'd5, 5'd7, 0, 0), k++);
    run_cycle(mk(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 5'd0, 5'd5, 5'd3, 0, 0), k++);

    // Transfer presented during a single reset cycle must be dropped.
    do_reset(1, mk(1, 5'd3, 32'h33, 0, 5'd0, 32'h0, 0, 5'd0, 5'd5, 5'd3, 0, 0));
    run_cycle(mk(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 5'd0, 5'd5, 5'd3, 0, 0), k++);
    run_cycle(mk(0, 5'd0, 32'h0, 1, 5'd8, 32'h88, 0, 5'd0, 5'd3, 5'd5, 0, 1), k++);
    run_cycle(idle, k++);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
